lcd_msg_reader: RTL and testbench
=================================

Name: lcd_msg_reader

Overview:
Read-side initiator for the LCD message ROM: 2048x8, synchronous read, 1-cycle latency, always enabled, no writes.
- On a start request, walks one 32-character message: drives the ROM address and captures the returned byte.
- Presents each character to the LCD character writer over a valid/ready handshake.
- Flags line boundaries (16 chars/line) and message completion.
- Sits between the message ROM and the LCD command/timing FSM.

Parameters:
ADDR_W, 11, ROM address width.
MSG_LEN, 32, characters per message.
LINE_LEN, 16, characters per LCD line.
TERM_CHAR, 8'hFF, end-of-message marker; not presented.

Ports:
clk  in  1  system clock, all logic on rising edge.
reset  in  1  asynchronous, active-high reset.
start  in  1  pulse: begin reading message msg_sel; honoured only in IDLE.
msg_sel  in  6  message index; base address = msg_sel*MSG_LEN; sampled with start.
abort  in  1  terminate current read, return to IDLE.
memory_addr  out  ADDR_W  registered ROM address.
data  in  8  ROM read data, valid one cycle after memory_addr.
char_data  out  8  character to LCD writer.
char_valid  out  1  char_data valid.
char_ready  in  1  LCD writer accepts char_data.
char_line  out  1  0 = line 1 (index 0..15), 1 = line 2 (index 16..31); qualified by char_valid.
line_start  out  1  current char is the first of its line (index 0 or 16); qualified by char_valid.
busy  out  1  high in any state except IDLE.
msg_done  out  1  one-cycle pulse when a message ends (length or terminator).

Behaviour:
- Reset (async) values: state IDLE; memory_addr=0; char_data=0; char_valid=0; char_line=0; line_start=0; busy=0; msg_done=0; index=0.
- FSM states: IDLE, ADDR, WAIT, PRESENT, DONE.
- IDLE -> ADDR on start. Latch base = msg_sel*MSG_LEN, truncated to ADDR_W. index=0. memory_addr=base.
- ADDR: address held; ROM samples at this edge. -> WAIT.
- WAIT: data is valid. If data==TERM_CHAR -> DONE, and the terminator is never presented. Otherwise capture data into char_data; set char_line=(index>=LINE_LEN); set line_start=(index%LINE_LEN==0); char_valid=1 -> PRESENT.
- PRESENT: hold char_data, char_line and line_start stable while char_valid && !char_ready.
  - On char_valid && char_ready: char_valid=0.
  - If index==MSG_LEN-1 -> DONE.
  - Else index+1, memory_addr+1 -> ADDR.
- DONE: msg_done=1 for exactly one cycle -> IDLE. busy drops on entry to IDLE.
- Latency: start at cycle N gives first char_valid at N+3. Each subsequent character takes 3 cycles minimum (ADDR, WAIT, PRESENT with ready high).
- Address arithmetic: memory_addr wraps modulo 2^ADDR_W. msg_sel=63 reads addresses 2016..2047; no carry out.
- start while busy: ignored, no queuing.
- abort: takes priority over every other transition. Next cycle goes to IDLE, char_valid=0, no msg_done, memory_addr holds its value. abort in IDLE has no effect.
- start and abort in the same cycle in IDLE: abort wins, start ignored.
- Terminator at index 0: no characters presented; msg_done pulses at N+3.
- Reset mid-transfer: immediate return to reset values. A character held in PRESENT is dropped.
- char_ready while char_valid=0: ignored.

Decomposition:
- Shared package lcd_pkg holds:
  - state enum, 3-bit encoding (IDLE=0, ADDR=1, WAIT=2, PRESENT=3, DONE=4);
  - constants MSG_LEN, LINE_LEN, TERM_CHAR, ADDR_W;
  - base addresses MSG0_BASE=0 and MSG1_BASE=32.
- No sub-module. Single FSM with an index counter and an address register. The ROM is instantiated alongside it by the parent.

Test Plan:
- Message 1, ready tied high: msg_sel=1 with a ROM model matching message 1 contents. Expect 32 chars 0x41..0x50, then 0x61..0x6F, then 0x20. line_start at index 0 and 16; char_line goes 1 from index 16; msg_done at the final step; total 96 cycles from start.
- Message 0 with terminator: byte 31=0xFF. Expect 31 chars presented and 0xFF never presented; msg_done one cycle after the WAIT that saw 0xFF.
- Backpressure: char_ready low for 5 cycles on index 3 (char 0x44). Expect char_valid/char_data held stable for all 5 cycles; memory_addr unchanged until accept; sequence continues with index 4 (0x45).
- start during busy, then abort: second start mid-message is ignored. abort at index 10 gives IDLE next cycle, char_valid=0, no msg_done. A fresh start then restarts at index 0.
- Async reset mid-PRESENT: all outputs go to 0 without a clock edge; the next start works normally.
- Wrap: msg_sel=63. Addresses 2016..2047 issued, no wrap to 0 within the message. Terminator at index 0 gives zero chars and msg_done at N+3.

Source files
------------

// File: rtl/lcd_msg_reader_pkg.sv
// Shared state encoding, message geometry and base-address helper for the
// LCD message ROM reader.
package lcd_pkg;

  localparam int ADDR_W   = 11;
  localparam int MSG_LEN  = 32;
  localparam int LINE_LEN = 16;
  localparam int SEL_W    = 6;
  localparam int IDX_W    = $clog2(MSG_LEN);
  localparam int COL_W    = $clog2(LINE_LEN);

  localparam logic [7:0] TERM_CHAR = 8'hFF;

  localparam logic [ADDR_W-1:0] MSG0_BASE = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] MSG1_BASE = ADDR_W'(32);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    WAIT    = 3'd2,
    PRESENT = 3'd3,
    DONE    = 3'd4
  } state_t;

  // First ROM address of a message; anything above the ROM size is dropped.
  function automatic logic [ADDR_W-1:0] msg_base(input logic [SEL_W-1:0] sel);
    logic [31:0] full;
    full = 32'(sel) * 32'(MSG_LEN);
    return full[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/lcd_msg_reader.sv
// Walks one message out of the synchronous message ROM and hands each
// character to the LCD writer over a valid/ready handshake.
module lcd_msg_reader
  import lcd_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [SEL_W-1:0]  msg_sel,
  input  logic              abort,
  output logic [ADDR_W-1:0] memory_addr,
  input  logic [7:0]        data,
  output logic [7:0]        char_data,
  output logic              char_valid,
  input  logic              char_ready,
  output logic              char_line,
  output logic              line_start,
  output logic              busy,
  output logic              msg_done
);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [IDX_W-1:0]   index_q, index_d;
  logic [7:0]         char_data_q, char_data_d;
  logic               char_valid_q, char_valid_d;
  logic               char_line_q, char_line_d;
  logic               line_start_q, line_start_d;
  logic               busy_q, busy_d;
  logic               msg_done_q, msg_done_d;

  logic               last_char;
  logic               second_line;
  logic               first_of_line;

  assign last_char     = (index_q == IDX_W'(MSG_LEN - 1));
  assign second_line   = (index_q >= IDX_W'(LINE_LEN));
  assign first_of_line = (index_q[COL_W-1:0] == '0);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    index_d      = index_q;
    char_data_d  = char_data_q;
    char_valid_d = char_valid_q;
    char_line_d  = char_line_q;
    line_start_d = line_start_q;
    msg_done_d   = 1'b0;

    // abort overrides everything, including a start arriving in IDLE
    if (abort) begin
      state_d      = IDLE;
      char_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = ADDR;
            addr_d  = msg_base(msg_sel);
            index_d = '0;
          end
        end
        ADDR: begin
          state_d = WAIT;
        end
        WAIT: begin
          if (data == TERM_CHAR) begin
            state_d    = DONE;
            msg_done_d = 1'b1;
          end else begin
            state_d      = PRESENT;
            char_data_d  = data;
            char_line_d  = second_line;
            line_start_d = first_of_line;
            char_valid_d = 1'b1;
          end
        end
        PRESENT: begin
          if (char_ready) begin
            char_valid_d = 1'b0;
            if (last_char) begin
              state_d    = DONE;
              msg_done_d = 1'b1;
            end else begin
              state_d = ADDR;
              index_d = index_q + 1'b1;
              addr_d  = addr_q + 1'b1;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d      = IDLE;
          char_valid_d = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      index_q      <= '0;
      char_data_q  <= '0;
      char_valid_q <= 1'b0;
      char_line_q  <= 1'b0;
      line_start_q <= 1'b0;
      busy_q       <= 1'b0;
      msg_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      index_q      <= index_d;
      char_data_q  <= char_data_d;
      char_valid_q <= char_valid_d;
      char_line_q  <= char_line_d;
      line_start_q <= line_start_d;
      busy_q       <= busy_d;
      msg_done_q   <= msg_done_d;
    end
  end

  assign memory_addr = addr_q;
  assign char_data   = char_data_q;
  assign char_valid  = char_valid_q;
  assign char_line   = char_line_q;
  assign line_start  = line_start_q;
  assign busy        = busy_q;
  assign msg_done    = msg_done_q;

endmodule

// File: tb/tb_lcd_msg_reader.sv
// Scoreboard bench for lcd_msg_reader: a ROM model feeds the reader, the
// expected character stream is derived from ROM contents and message rules.
module tb_lcd_msg_reader;
  import lcd_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              abort;
  logic              char_ready;
  logic [SEL_W-1:0]  msg_sel;
  logic [7:0]        data;
  logic [ADDR_W-1:0] memory_addr;
  logic [7:0]        char_data;
  logic              char_valid;
  logic              char_line;
  logic              line_start;
  logic              busy;
  logic              msg_done;

  lcd_msg_reader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .msg_sel    (msg_sel),
    .abort      (abort),
    .memory_addr(memory_addr),
    .data       (data),
    .char_data  (char_data),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .char_line  (char_line),
    .line_start (line_start),
    .busy       (busy),
    .msg_done   (msg_done)
  );

  always #5 clk = ~clk;

  // Message ROM: 2048x8, one-cycle synchronous read, always enabled.
  logic [7:0] rom [0:(1<<ADDR_W)-1];
  always @(posedge clk) data <= rom[memory_addr];

  typedef struct packed {
    logic [7:0]        ch;
    logic              line;
    logic              ls;
    logic [ADDR_W-1:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   exp_done = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   ready_rand = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_cmp++;
    n_err++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Reference model: characters of message sel up to the terminator, the
  // message length or 'upto', whichever comes first.
  task automatic expect_msg(input int sel, input bit with_done, input int upto, output int nchars);
    int base;
    base = sel * MSG_LEN;
    nchars = 0;
    for (int i = 0; i < MSG_LEN && i < upto; i++) begin
      if (rom[base + i] == TERM_CHAR) break;
      exp_q.push_back('{ch: rom[base + i], line: (i >= LINE_LEN), ls: ((i % LINE_LEN) == 0),
                        addr: ADDR_W'(base + i)});
      nchars++;
    end
    if (with_done) exp_done++;
  endtask

  // Monitor: pops the scoreboard on each accepted character, checks msg_done
  // placement and stability of a stalled character.
  logic [31:0] held = '0;
  bit          hold = 0;
  exp_t        mon_e;
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        hold = 0;
      end else begin
        if (hold) begin
          check("hold_valid", 32'(char_valid), 32'd1);
          check("hold_stable", 32'({char_data, char_line, line_start, memory_addr}), held);
        end
        if (char_valid && char_ready) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected_char", $sformatf("actual=0x%0h required=no character", char_data));
          end else begin
            mon_e = exp_q.pop_front();
            check("char", 32'({char_data, char_line, line_start, memory_addr}), 32'(mon_e));
          end
        end
        if (msg_done) begin
          n_cmp++;
          if (exp_done == 0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL msg_done: actual=pulse with %0d chars pending, %0d ends expected; required=pulse after all chars",
                     exp_q.size(), exp_done);
          end else begin
            exp_done--;
          end
        end
        hold = char_valid && !char_ready && !abort;
        held = 32'({char_data, char_line, line_start, memory_addr});
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_rand) char_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic wait_valid(input int budget, input string name);
    bit seen;
    seen = 0;
    for (int k = 0; k < budget; k++) begin
      if (char_valid) begin
        seen = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!seen) fail_now(name, "actual=no char_valid required=char_valid within budget");
  endtask

  task automatic wait_done(input int budget, input string name);
    bit seen;
    seen = 0;
    for (int k = 0; k < budget; k++) begin
      if (msg_done) begin
        seen = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!seen) fail_now(name, "actual=no msg_done required=msg_done within budget");
    @(posedge clk);
    #1;
    check({name, "_pulse_width"}, 32'(msg_done), 32'd0);
    check({name, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  // Issues a start and follows the message to its end; cycle numbers count
  // the start cycle as N, so the cycle right after the sampling edge is N+1.
  task automatic run_msg(input int sel, output int first_c, output int done_c, output int nchars);
    expect_msg(sel, 1, MSG_LEN, nchars);
    first_c = -1;
    done_c  = -1;
    msg_sel = SEL_W'(sel);
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c < 4000; c++) begin
      if (char_valid && first_c < 0) first_c = c;
      if (msg_done) begin
        done_c = c;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (done_c < 0) fail_now("run_timeout", "actual=no msg_done required=msg_done");
    @(posedge clk);
    #1;
    check("done_pulse_width", 32'(msg_done), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
    $display("msg sel=%0d chars=%0d first_valid=N+%0d done=N+%0d", sel, nchars, first_c, done_c);
  endtask

  int first_c, done_c, nchars;
  logic [ADDR_W-1:0] addr_snap;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    char_ready = 1'b0;
    msg_sel = '0;
    for (int i = 0; i < (1 << ADDR_W); i++) rom[i] = 8'($urandom_range(0, 254));
    for (int i = 0; i < 16; i++) rom[32 + i] = 8'(8'h41 + i);
    for (int i = 0; i < 15; i++) rom[48 + i] = 8'(8'h61 + i);
    rom[63] = 8'h20;
    rom[31] = TERM_CHAR;

    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'({memory_addr, char_data, char_valid, char_line, line_start, busy, msg_done}), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Message 1 with ready tied high.
    char_ready = 1'b1;
    run_msg(1, first_c, done_c, nchars);
    check("msg1_chars", 32'(nchars), 32'd32);
    check("msg1_first_latency", 32'(first_c), 32'd3);
    check("msg1_done_cycle", 32'(done_c), 32'd97);

    // Message 0: terminator in the last slot.
    run_msg(0, first_c, done_c, nchars);
    check("msg0_chars", 32'(nchars), 32'd31);
    check("msg0_done_cycle", 32'(done_c), 32'd96);

    // Backpressure on index 3.
    expect_msg(1, 1, MSG_LEN, nchars);
    msg_sel = SEL_W'(1);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (memory_addr == ADDR_W'(35) && !char_valid) break;
      @(posedge clk);
      #1;
    end
    char_ready = 1'b0;
    wait_valid(10, "bp_valid");
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("bp_held", 32'({char_valid, char_data, memory_addr}), 32'({1'b1, 8'h44, ADDR_W'(35)}));
    end
    char_ready = 1'b1;
    wait_done(200, "bp_done");
    $display("backpressure message finished, %0d chars", nchars);

    // Start while busy is ignored; abort at index 10.
    char_ready = 1'b0;
    expect_msg(1, 0, 10, nchars);
    msg_sel = SEL_W'(1);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int idx = 0; idx <= 10; idx++) begin
      wait_valid(20, "abort_wait_valid");
      if (idx == 10) begin
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_state", 32'({char_valid, busy, msg_done}), 32'd0);
        check("abort_addr_hold", 32'(memory_addr), 32'd42);
      end else begin
        char_ready = 1'b1;
        if (idx == 5) begin
          start = 1'b1;
          msg_sel = SEL_W'(2);
        end
        @(posedge clk);
        #1;
        char_ready = 1'b0;
        start = 1'b0;
        msg_sel = SEL_W'(1);
      end
    end
    repeat (3) begin
      @(posedge clk);
      #1;
      check("abort_no_done", 32'(msg_done), 32'd0);
    end
    check("abort_chars_consumed", 32'(exp_q.size()), 32'd0);
    $display("aborted message at index 10");
    char_ready = 1'b1;
    run_msg(1, first_c, done_c, nchars);
    check("restart_first_latency", 32'(first_c), 32'd3);

    // abort and start together in IDLE: nothing starts.
    addr_snap = memory_addr;
    start = 1'b1;
    abort = 1'b1;
    msg_sel = SEL_W'(5);
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    check("abort_start_idle", 32'({busy, memory_addr}), 32'({1'b0, addr_snap}));
    $display("start+abort in idle ignored");

    // Asynchronous reset while a character is stalled.
    char_ready = 1'b0;
    expect_msg(1, 1, MSG_LEN, nchars);
    msg_sel = SEL_W'(1);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_valid(10, "rst_wait_valid");
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", 32'({memory_addr, char_data, char_valid, char_line, line_start, busy, msg_done}), 32'd0);
    exp_q.delete();
    exp_done = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    $display("reset mid-present");
    char_ready = 1'b1;
    run_msg(1, first_c, done_c, nchars);
    check("post_reset_done_cycle", 32'(done_c), 32'd97);

    // Top message: addresses 2016..2047, then terminator at index 0.
    for (int i = 0; i < MSG_LEN; i++) rom[2016 + i] = 8'($urandom_range(0, 254));
    run_msg(63, first_c, done_c, nchars);
    check("wrap_chars", 32'(nchars), 32'd32);
    rom[2016] = TERM_CHAR;
    run_msg(63, first_c, done_c, nchars);
    check("term0_chars", 32'(nchars), 32'd0);
    check("term0_done_cycle", 32'(done_c), 32'd3);
    check("term0_no_valid", 32'(first_c), 32'hFFFF_FFFF);

    // Random messages and random backpressure.
    ready_rand = 1;
    for (int t = 0; t < 10; t++) begin
      int sel;
      sel = $urandom_range(0, 63);
      for (int i = 0; i < MSG_LEN; i++) rom[sel * MSG_LEN + i] = 8'($urandom_range(0, 254));
      if ($urandom_range(0, 1) == 1) rom[sel * MSG_LEN + $urandom_range(0, MSG_LEN - 1)] = TERM_CHAR;
      run_msg(sel, first_c, done_c, nchars);
    end
    ready_rand = 0;

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("done_all_seen", 32'(exp_done), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
